// File: rtl/alu_ctrl_issue.sv
// ---------------------------------------------------------------------------
// alu_ctrl_issue
//   Registered ALU-control decoder with a one-entry output stage. It decodes
//   {alu_op, funct} into an ALU control code and holds it until the ALU takes
//   it. A MUL decode is sequenced for MUL_CYCLES edges before it is issued.
//
// Parameters
//   FUNCT_W    : width of funct (>= 3)
//   CTRL_W     : width of alu_control (>= 3); codes are zero-extended
//   MUL_CYCLES : edges from MUL acceptance to out_valid (>= 2)
//
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high reset
//   in_valid    : decode request present
//   in_ready    : request can be accepted this cycle
//   alu_op      : operation class from main control
//   funct       : instruction function field
//   out_valid   : alu_control / multi_cycle valid
//   out_ready   : ALU consumes the output this cycle
//   alu_control : registered ALU control code
//   multi_cycle : issued op was MUL
//   busy        : MUL sequencing in progress
//
// Optional feature (macro ALU_CTRL_ERR_EN)
//   err_flag    : sticky flag, set when an illegal decode is accepted
//   err_clr     : clears err_flag (a coincident set wins)
// ---------------------------------------------------------------------------
module alu_ctrl_issue #(
   parameter int FUNCT_W    = 3,
   parameter int CTRL_W     = 3,
   parameter int MUL_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         alu_op,
   input  logic [FUNCT_W-1:0] funct,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CTRL_W-1:0]  alu_control,
   output logic               multi_cycle,
   output logic               busy
`ifdef ALU_CTRL_ERR_EN
   ,
   output logic               err_flag,
   input  logic               err_clr
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_MULTI = 2'd2;

   localparam logic [2:0] C_ILL = 3'b000;
   localparam logic [2:0] C_ADD = 3'b001;
   localparam logic [2:0] C_SUB = 3'b010;
   localparam logic [2:0] C_AND = 3'b011;
   localparam logic [2:0] C_OR  = 3'b100;
   localparam logic [2:0] C_SLT = 3'b101;
   localparam logic [2:0] C_MUL = 3'b110;

   localparam int CNT_W = $clog2(MUL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic             mul_q, mul_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0]       dec_code;
   logic             dec_mul;
   logic             funct_hi_nz;
   logic             accept;

   // Upper funct bits only exist for FUNCT_W > 3; any set bit there is illegal.
   if (FUNCT_W > 3) begin : g_funct_hi
      assign funct_hi_nz = |funct[FUNCT_W-1:3];
   end else begin : g_no_funct_hi
      assign funct_hi_nz = 1'b0;
   end

   // Code 000 is produced only by illegal decodes, so it doubles as the
   // illegal indication for the error flag.
   always_comb begin
      dec_code = C_ILL;
      dec_mul  = 1'b0;
      case (alu_op)
         2'b00: dec_code = C_ADD;
         2'b01: dec_code = C_SUB;
         2'b10: begin
            if (!funct_hi_nz) begin
               case (funct[2:0])
                  3'b000: dec_code = C_ADD;
                  3'b010: dec_code = C_SUB;
                  3'b100: dec_code = C_AND;
                  3'b101: dec_code = C_OR;
                  3'b110: dec_code = C_SLT;
                  3'b001: begin
                     dec_code = C_MUL;
                     dec_mul  = 1'b1;
                  end
                  default: dec_code = C_ILL;
               endcase
            end
         end
         default: dec_code = C_ILL;
      endcase
   end

   assign out_valid   = (state_q == S_HOLD);
   assign busy        = (state_q == S_MULTI);
   assign in_ready    = !reset && (state_q != S_MULTI) && (!out_valid || out_ready);
   assign accept      = in_valid && in_ready;
   assign alu_control = CTRL_W'(ctrl_q);
   assign multi_cycle = mul_q;

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      mul_d   = mul_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_MULTI: begin
            // Leaving on count 1 makes acceptance-to-valid exactly MUL_CYCLES edges.
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_HOLD;
            end
         end
         default: begin
            // IDLE or HOLD: accept covers the back-to-back case from HOLD.
            if (accept) begin
               ctrl_d = dec_code;
               mul_d  = dec_mul;
               if (dec_mul) begin
                  state_d = S_MULTI;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = S_HOLD;
               end
            end else if (state_q == S_HOLD && out_ready) begin
               state_d = S_IDLE;
            end else if (state_q != S_HOLD) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ctrl_q  <= C_ILL;
         mul_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         mul_q   <= mul_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef ALU_CTRL_ERR_EN
   logic err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (accept && dec_code == C_ILL) begin
         err_q <= 1'b1;
      end else if (err_clr) begin
         err_q <= 1'b0;
      end
   end

   assign err_flag = err_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
module tb_alu_ctrl_issue;
   localparam int FUNCT_W    = 4;
   localparam int CTRL_W     = 4;
   localparam int MUL_CYCLES = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         alu_op;
   logic [FUNCT_W-1:0] funct;
   logic               out_valid;
   logic               out_ready;
   logic [CTRL_W-1:0]  alu_control;
   logic               multi_cycle;
   logic               busy;
`ifdef ALU_CTRL_ERR_EN
   logic               err_flag;
   logic               err_clr;
   logic               err_exp;
`endif

   alu_ctrl_issue #(
      .FUNCT_W(FUNCT_W), .CTRL_W(CTRL_W), .MUL_CYCLES(MUL_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
      .alu_control(alu_control), .multi_cycle(multi_cycle), .busy(busy)
`ifdef ALU_CTRL_ERR_EN
      , .err_flag(err_flag), .err_clr(err_clr)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] code;
      logic       mul;
      int         ready;   // cycle index at which the item becomes visible
   } item_t;

   item_t q[$];
   int    cyc = 0;
   int    n_tests = 0;
   int    n_fail = 0;
   bit    started = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference decode straight from the opcode table: {illegal, mul, code}.
   function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [FUNCT_W-1:0] f);
      if (op == 2'b00) return 5'b00_001;
      if (op == 2'b01) return 5'b00_010;
      if (op == 2'b10 && f[FUNCT_W-1:3] == '0) begin
         case (f[2:0])
            3'b000: return 5'b00_001;
            3'b010: return 5'b00_010;
            3'b100: return 5'b00_011;
            3'b101: return 5'b00_100;
            3'b110: return 5'b00_101;
            3'b001: return 5'b01_110;
            default: return 5'b10_000;
         endcase
      end
      return 5'b10_000;
   endfunction

   // Monitor: compares DUT outputs with the queue-based model every cycle.
   always @(negedge clk) begin
      if (started && !reset) begin
         logic exp_v, exp_b;
         exp_v = (q.size() > 0) && (q[0].ready <= cyc);
         exp_b = (q.size() > 0) && (q[0].ready > cyc);
         chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
         chk("busy", {31'b0, busy}, {31'b0, exp_b});
         chk("in_ready", {31'b0, in_ready}, {31'b0, !exp_b && (!exp_v || out_ready)});
         if (exp_v) begin
            chk("alu_control", {{(32-CTRL_W){1'b0}}, alu_control}, {29'b0, q[0].code});
            chk("multi_cycle", {31'b0, multi_cycle}, {31'b0, q[0].mul});
         end
`ifdef ALU_CTRL_ERR_EN
         chk("err_flag", {31'b0, err_flag}, {31'b0, err_exp});
`endif
         if (exp_v && out_ready) void'(q.pop_front());
      end
   end

   // One cycle of stimulus; the accepted request is pushed to the model.
   task automatic step(input logic v, input logic [1:0] op, input logic [FUNCT_W-1:0] f,
                       input logic r, input logic c);
      logic       acc;
      logic [4:0] d;
      int         c_acc;
      in_valid  = v;
      alu_op    = op;
      funct     = f;
      out_ready = r;
`ifdef ALU_CTRL_ERR_EN
      err_clr   = c;
`endif
      @(negedge clk);
      acc   = in_valid && in_ready;
      d     = ref_dec(op, f);
      c_acc = cyc;
      @(posedge clk);
      if (acc) q.push_back('{code: d[2:0], mul: d[3], ready: c_acc + (d[3] ? MUL_CYCLES : 1)});
`ifdef ALU_CTRL_ERR_EN
      if (acc && d[4]) err_exp = 1'b1;
      else if (c) err_exp = 1'b0;
`endif
      #1;
   endtask

   task automatic reset_checks();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_alu_control", {{(32-CTRL_W){1'b0}}, alu_control}, 32'd0);
      chk("rst_multi_cycle", {31'b0, multi_cycle}, 32'd0);
`ifdef ALU_CTRL_ERR_EN
      chk("rst_err_flag", {31'b0, err_flag}, 32'd0);
`endif
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = '0; out_ready = 1'b0;
`ifdef ALU_CTRL_ERR_EN
      err_clr = 1'b0; err_exp = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset_checks();
      reset = 1'b0;
      started = 1;

      // Back-to-back ADD then SUB
      step(1, 2'b00, 4'b0000, 1, 0);
      step(1, 2'b01, 4'b0000, 1, 0);
      // R-type sweep
      step(1, 2'b10, 4'b0000, 1, 0);
      step(1, 2'b10, 4'b0010, 1, 0);
      step(1, 2'b10, 4'b0100, 1, 0);
      step(1, 2'b10, 4'b0101, 1, 0);
      step(1, 2'b10, 4'b0110, 1, 0);
      step(0, 2'b00, 4'b0000, 1, 0);
      // MUL with a competing request held during sequencing
      step(1, 2'b10, 4'b0001, 1, 0);
      repeat (MUL_CYCLES + 1) step(1, 2'b01, 4'b0000, 1, 0);
      step(0, 2'b00, 4'b0000, 1, 0);
      // Backpressure on SUB
      step(1, 2'b01, 4'b0000, 0, 0);
      repeat (5) step(1, 2'b00, 4'b0000, 0, 0);
      step(0, 2'b00, 4'b0000, 1, 0);
      step(0, 2'b00, 4'b0000, 1, 0);
      // Illegal decodes, error flag set / clear / coincident
      step(1, 2'b11, 4'b0000, 1, 0);
      step(1, 2'b10, 4'b0111, 1, 0);
      step(1, 2'b10, 4'b1000, 1, 0);
      step(0, 2'b00, 4'b0000, 1, 1);
      step(0, 2'b00, 4'b0000, 1, 0);
      step(1, 2'b11, 4'b0000, 1, 1);
      step(0, 2'b00, 4'b0000, 1, 1);
      step(0, 2'b00, 4'b0000, 1, 0);
      // Reset two cycles into a MUL
      step(1, 2'b10, 4'b0001, 1, 0);
      step(0, 2'b00, 4'b0000, 1, 0);
      step(0, 2'b00, 4'b0000, 1, 0);
      reset = 1'b1;
      #1;
      reset_checks();
      q.delete();
`ifdef ALU_CTRL_ERR_EN
      err_exp = 1'b0;
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (MUL_CYCLES + 2) step(0, 2'b00, 4'b0000, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [FUNCT_W-1:0] f;
         f = FUNCT_W'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) f[FUNCT_W-1] = 1'b1;
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), f,
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end
      repeat (MUL_CYCLES + 2) step(0, 2'b00, 4'b0000, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
